// File: rtl/crypto_word_sequencer.sv
// Sequential front-end for the combinational byte-chained XOR cipher core:
// accepts one word, steps the core through bytes 0..3 and returns the assembled result.
module crypto_word_sequencer #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [31:0]      in_key,
    input  logic             in_sel,
    output logic [31:0]      core_data_in,
    output logic [31:0]      core_key,
    output logic             core_sel,
    output logic [1:0]       core_cnt,
    input  logic [31:0]      core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("crypto_word_sequencer: SETTLE_CYC must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  settle_q;
    logic [31:0] acc_q;
    logic [31:0] acc_merged;
    logic        accept;
    logic        drain;
    logic        step_last;

    assign accept    = (state_q == S_IDLE) && in_valid && in_ready;
    assign drain     = (state_q == S_DONE) && out_valid && out_ready;
    assign step_last = (state_q == S_RUN) && (settle_q == SETTLE_LAST);
    assign busy      = (state_q != S_IDLE);

    // Only the byte selected by the current step is taken from the core.
    always_comb begin
        acc_merged = acc_q;
        case (core_cnt)
            2'd0: acc_merged[7:0]   = core_result[7:0];
            2'd1: acc_merged[15:8]  = core_result[15:8];
            2'd2: acc_merged[23:16] = core_result[23:16];
            2'd3: acc_merged[31:24] = core_result[31:24];
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (step_last && core_cnt == 2'd3) state_d = S_DONE;
            S_DONE:  if (drain) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_data     <= '0;
            core_data_in <= '0;
            core_key     <= '0;
            core_sel     <= 1'b0;
            core_cnt     <= '0;
            settle_q     <= '0;
            acc_q        <= '0;
            words_done   <= '0;
        end else begin
            if (accept) begin
                core_data_in <= in_data;
                core_key     <= in_key;
                core_sel     <= in_sel;
                core_cnt     <= '0;
                settle_q     <= '0;
                acc_q        <= '0;
                in_ready     <= 1'b0;
            end

            if (state_q == S_RUN) begin
                if (step_last) begin
                    acc_q    <= acc_merged;
                    settle_q <= '0;
                    // Wraps 3 -> 0 so the core idles on step 0 after the word.
                    core_cnt <= core_cnt + 2'd1;
                    if (core_cnt == 2'd3) begin
                        out_data  <= acc_merged;
                        out_valid <= 1'b1;
                    end
                end else begin
                    settle_q <= settle_q + 4'd1;
                end
            end

            if (drain) begin
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
                if (~&words_done) begin
                    words_done <= words_done + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_crypto_word_sequencer.sv
// Bench for crypto_word_sequencer: two instances (SETTLE_CYC=1/CNT_W=16 and
// SETTLE_CYC=3/CNT_W=2), each driving a behavioural cipher core model.
module tb_crypto_word_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic dsel;
    logic in_valid;
    logic in_sel;
    logic out_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;

    logic        in_valid_a, in_ready_a, core_sel_a, out_valid_a, busy_a;
    logic [31:0] core_data_in_a, core_key_a, core_result_a, out_data_a;
    logic [1:0]  core_cnt_a;
    logic [15:0] words_done_a;

    logic        in_valid_b, in_ready_b, core_sel_b, out_valid_b, busy_b;
    logic [31:0] core_data_in_b, core_key_b, core_result_b, out_data_b;
    logic [1:0]  core_cnt_b;
    logic [1:0]  words_done_b;

    logic        in_ready, core_sel, out_valid, busy;
    logic [31:0] core_data_in, core_key, out_data;
    logic [1:0]  core_cnt;
    logic [15:0] words_done;

    int n_pass  = 0;
    int n_total = 0;
    int wd_exp  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] d;
        logic [31:0] k;
        logic        s;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Reference byte-chained cipher, IV = 0x9B, byte 0 processed first.
    function automatic logic [31:0] cipher(input logic [31:0] d, input logic [31:0] k, input logic s);
        logic [7:0]  prev;
        logic [7:0]  ob;
        logic [31:0] r;
        prev = 8'h9B;
        r    = '0;
        for (int i = 0; i < 4; i++) begin
            ob          = prev ^ d[8*i +: 8] ^ k[8*i +: 8];
            r[8*i +: 8] = ob;
            prev        = s ? d[8*i +: 8] : ob;
        end
        return r;
    endfunction

    // Only the byte addressed by cnt is correct; the rest are corrupted so a
    // sequencer sampling the wrong byte at the wrong step is exposed.
    function automatic logic [31:0] core_model(input logic [31:0] d, input logic [31:0] k,
                                               input logic s, input logic [1:0] cnt);
        logic [31:0] keep;
        keep = 32'hFF << (8 * cnt);
        return cipher(d, k, s) ^ (32'hA5A5A5A5 & ~keep);
    endfunction

    assign core_result_a = core_model(core_data_in_a, core_key_a, core_sel_a, core_cnt_a);
    assign core_result_b = core_model(core_data_in_b, core_key_b, core_sel_b, core_cnt_b);

    assign in_valid_a = in_valid && !dsel;
    assign in_valid_b = in_valid && dsel;

    assign in_ready     = dsel ? in_ready_b     : in_ready_a;
    assign core_sel     = dsel ? core_sel_b     : core_sel_a;
    assign out_valid    = dsel ? out_valid_b    : out_valid_a;
    assign busy         = dsel ? busy_b         : busy_a;
    assign core_data_in = dsel ? core_data_in_b : core_data_in_a;
    assign core_key     = dsel ? core_key_b     : core_key_a;
    assign out_data     = dsel ? out_data_b     : out_data_a;
    assign core_cnt     = dsel ? core_cnt_b     : core_cnt_a;
    assign words_done   = dsel ? {14'd0, words_done_b} : words_done_a;

    crypto_word_sequencer #(.SETTLE_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data), .in_key(in_key), .in_sel(in_sel),
        .core_data_in(core_data_in_a), .core_key(core_key_a), .core_sel(core_sel_a),
        .core_cnt(core_cnt_a), .core_result(core_result_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .busy(busy_a), .words_done(words_done_a)
    );

    crypto_word_sequencer #(.SETTLE_CYC(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .in_key(in_key), .in_sel(in_sel),
        .core_data_in(core_data_in_b), .core_key(core_key_b), .core_sel(core_sel_b),
        .core_cnt(core_cnt_b), .core_result(core_result_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .busy(busy_b), .words_done(words_done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: a handshake happens on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                check("sb_out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},     32'(in_ready),  32'd1);
        check({tag, "_out_valid"},    32'(out_valid), 32'd0);
        check({tag, "_out_data"},     out_data,       32'd0);
        check({tag, "_core_data_in"}, core_data_in,   32'd0);
        check({tag, "_core_key"},     core_key,       32'd0);
        check({tag, "_core_sel"},     32'(core_sel),  32'd0);
        check({tag, "_core_cnt"},     32'(core_cnt),  32'd0);
        check({tag, "_busy"},         32'(busy),      32'd0);
        check({tag, "_words_done"},   32'(words_done), 32'd0);
    endtask

    // Called on a falling edge with out_ready=1; returns one cycle after the handshake.
    task automatic run_word(input logic [31:0] d, input logic [31:0] k, input logic s,
                            input logic [31:0] exp, input int settle, input int wd_cap);
        int lat = 0;
        int exp_cnt;
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_key   = k;
        in_sel   = s;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 4 * settle + 1; c++) begin
            @(negedge clk);
            exp_cnt = (c <= 4 * settle) ? (c - 1) / settle : 0;
            check("core_cnt_step", 32'(core_cnt), 32'(exp_cnt));
            if (c == 1) begin
                check("core_data_in", core_data_in, d);
                check("core_key", core_key, k);
                check("core_sel", 32'(core_sel), 32'(s));
                check("busy_run", 32'(busy), 32'd1);
                check("in_ready_run", 32'(in_ready), 32'd0);
            end
            if (out_valid && lat == 0) lat = c;
        end
        check("out_valid_latency", 32'(lat), 32'(4 * settle + 1));
        @(negedge clk);
        if (wd_exp < wd_cap) wd_exp++;
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("busy_after_hs", 32'(busy), 32'd0);
        check("words_done", 32'(words_done), 32'(wd_exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit saw_valid;

        vecs[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h9B9B9B9B};
        vecs[1] = '{32'h11223344, 32'h01020304, 1'b0, 32'hDBCBEBDB};
        vecs[2] = '{32'hDBCBEBDB, 32'h01020304, 1'b1, 32'h11223344};
        vecs[3] = '{32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h9B649B64};
        vecs[4] = '{32'h9B649B64, 32'h00000000, 1'b1, 32'hFFFFFFFF};
        vecs[5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h9B649B64};

        rst_n = 1'b0; dsel = 1'b0; in_valid = 1'b0; in_sel = 1'b0;
        in_data = '0; in_key = '0; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 check_reset_vals("rst_a");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) check_reset_vals("rst_a_release");

        // Table-driven words on the SETTLE_CYC=1 instance.
        for (int i = 0; i < 6; i++) begin
            run_word(vecs[i].d, vecs[i].k, vecs[i].s, vecs[i].exp, 1, 65535);
        end

        // Downstream stall: everything holds and a new in_valid is ignored.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11223344; in_key = 32'h01020304; in_sel = 1'b0;
        exp_q.push_back(32'hDBCBEBDB);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_out_valid_seen", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", out_data, 32'hDBCBEBDB);
            check("stall_core_data_in", core_data_in, 32'h11223344);
            check("stall_core_key", core_key, 32'h01020304);
            check("stall_core_sel", 32'(core_sel), 32'd0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            if (i == 3) begin
                in_valid = 1'b1; in_data = 32'hCAFEF00D; in_key = 32'h12345678; in_sel = 1'b1;
            end
            if (i == 4) in_valid = 1'b0;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        wd_exp++;
        check("stall_in_ready_after", 32'(in_ready), 32'd1);
        check("stall_out_valid_after", 32'(out_valid), 32'd0);
        check("stall_words_done", 32'(words_done), 32'(wd_exp));

        // Reset asserted during step 2: word dropped, no output.
        in_valid = 1'b1; in_data = 32'h11223344; in_key = 32'h01020304; in_sel = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_run_cnt_step2", 32'(core_cnt), 32'd2);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst_mid_run");
        @(negedge clk) rst_n = 1'b1;
        wd_exp = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("rst_no_out_valid", 32'(saw_valid), 32'd0);
        check("rst_in_ready_idle", 32'(in_ready), 32'd1);
        run_word(32'h00000000, 32'h00000000, 1'b0, 32'h9B9B9B9B, 1, 65535);

        // SETTLE_CYC=3, CNT_W=2 instance: slow stepping and counter saturation.
        dsel = 1'b1;
        wd_exp = 0;
        @(negedge clk);
        check("b_words_done_init", 32'(words_done), 32'd0);
        run_word(32'h11223344, 32'h01020304, 1'b0, 32'hDBCBEBDB, 3, 3);
        for (int i = 2; i < 6; i++) begin
            run_word(vecs[i].d, vecs[i].k, vecs[i].s, vecs[i].exp, 3, 3);
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crypto_word_sequencer.md
Name: crypto_word_sequencer

Overview:
- Sequential front-end for the team's combinational 32-bit byte-chained XOR cipher core (ports data_in, key, cnt[1:0], sel, result).
- Accepts one plaintext/ciphertext word plus key and mode over a valid/ready handshake, then holds data_in/key/sel stable on the core.
- Steps the core's cnt through 0..3 and captures result byte k at step k.
- Presents the assembled 32-bit word downstream over a valid/ready handshake.

Parameters:
- SETTLE_CYC, 1, clock cycles cnt is held per step before result byte is sampled (1..15).
- CNT_W, 16, width of processed-word counter (saturating).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  32  word to process.
- in_key  input  32  key for this word.
- in_sel  input  1  0 = encrypt (chain on previous output byte), 1 = decrypt (chain on previous input byte).
- core_data_in  output  32  registered in_data driven to core data_in.
- core_key  output  32  registered in_key driven to core key.
- core_sel  output  1  registered in_sel driven to core sel.
- core_cnt  output  2  byte step driven to core cnt.
- core_result  input  32  core result.
- out_valid  output  1  processed word available.
- out_ready  input  1  downstream accepts the word.
- out_data  output  32  processed word.
- busy  output  1  high in RUN or DONE.
- words_done  output  CNT_W  count of completed output handshakes, saturating at all-ones.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE, in_ready=1, out_valid=0, out_data=0, core_data_in=0, core_key=0, core_sel=0, core_cnt=0, busy=0, words_done=0, internal settle counter=0.
- FSM states and transitions:
  - IDLE -> RUN on in_valid && in_ready.
  - RUN -> DONE after step 3 is sampled.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state==IDLE), registered. in_valid is ignored in RUN and DONE; there is no back-to-back overlap.
- Accept edge (cycle T): latch in_data, in_key, in_sel onto core_* outputs; core_cnt=0; settle counter=0; clear the internal result accumulator.
- RUN step k (k=0..3):
  - core_cnt=k for SETTLE_CYC cycles.
  - On the last of those cycles, accumulator[8k+7:8k] <= core_result[8k+7:8k], other accumulator bytes are unchanged, then core_cnt <= k+1.
  - After k=3, core_cnt returns to 0.
- Latency: with SETTLE_CYC=1, out_valid rises at T+5. In general: T+1+4*SETTLE_CYC.
- DONE: out_valid=1, out_data=accumulator. out_data, core_data_in, core_key and core_sel stay stable until the handshake.
- Output handshake cycle: out_valid drops next cycle, words_done increments (saturating), in_ready rises next cycle.
- core_* outputs hold their last values in IDLE. They change only on accept.
- out_data retains its last value after the handshake. It is meaningful only while out_valid=1.
- Reset mid-RUN or mid-DONE: the word is discarded, no output is produced, and all outputs return to their reset values.
- SETTLE_CYC=0 or >15 is illegal; an elaboration-time check reports an error.
- Expected core arithmetic, used for checking (IV=0x9B):
  - Encrypt: c0 = IV^d0^k0; ck = c(k-1)^dk^kk.
  - Decrypt: p0 = IV^c0^k0; pk = c(k-1)^ck^kk.

Test Plan:
- Reset, then encrypt in_data=0x00000000, in_key=0x00000000, sel=0, out_ready=1 -> out_valid at T+5, out_data=0x9B9B9B9B, words_done=1.
- Encrypt 0x11223344 with key 0x01020304 -> out_data=0xDBCBEBDB. Decrypt 0xDBCBEBDB with the same key, sel=1 -> out_data=0x11223344. core_cnt sequence 0,1,2,3,0 on both words.
- Hold out_ready=0 for 10 cycles after DONE -> out_valid, out_data and core_* stable; in_ready=0; a new in_valid pulse is ignored. Release out_ready -> one handshake, in_ready=1 next cycle.
- SETTLE_CYC=3, encrypt 0x11223344 / key 0x01020304 -> each core_cnt value held 3 cycles, out_valid at T+13, out_data=0xDBCBEBDB.
- Assert rst_n=0 during step 2 -> immediate return to reset values, no out_valid. The next word 0x00000000 / key 0 encrypts to 0x9B9B9B9B.
- CNT_W=2, perform 5 transfers -> words_done reads 1,2,3,3,3.
